// File: rtl/iplen_trim_pkg.sv
// iplen_pkg: FSM states, status-word bit positions and the status-word layout for iplen_trim.
package iplen_pkg;
    typedef enum logic [1:0] {HDR, PASS, DROP, STAT} state_t;
    localparam int STAT_LEN_ERR_BIT = 18;
    localparam int STAT_SHORT_BIT = 17;
    localparam int STAT_PADDED_BIT = 16;
    typedef struct packed {
        logic        len_err;
        logic        short_frame;
        logic        padded;
        logic [15:0] total_length;
    } stat_word_t;
endpackage

// File: rtl/iplen_trim_out_reg.sv
// iplen_out_reg: single-entry valid/ready register driving the m_* byte stream.
module iplen_out_reg (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       m_tvalid,
    input  logic       m_tready,
    output logic [7:0] m_tdata,
    output logic       m_tlast
);
    assign in_ready = ~m_tvalid | m_tready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tvalid <= 1'b0;
            m_tdata  <= 8'd0;
            m_tlast  <= 1'b0;
        end else if (in_valid && in_ready) begin
            m_tvalid <= 1'b1;
            m_tdata  <= in_data;
            m_tlast  <= in_last;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end
endmodule

// File: rtl/iplen_trim.sv
// iplen_trim: forwards exactly IP Total Length bytes, drops Ethernet pad, emits one status word per frame.
// Define IPLEN_TRIM_STATS_EN to add 32-bit saturating frame/padded/short/len_err counters.
module iplen_trim
    import iplen_pkg::*;
#(
    parameter int LEN_OFFSET = 2,
    parameter int MIN_LEN = 20,
    parameter int MAX_LEN = 1500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_tvalid,
    output logic        s_tready,
    input  logic [7:0]  s_tdata,
    input  logic        s_tlast,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic [7:0]  m_tdata,
    output logic        m_tlast,
    output logic        stat_tvalid,
    input  logic        stat_tready,
`ifdef IPLEN_TRIM_STATS_EN
    output logic [31:0] cnt_frames,
    output logic [31:0] cnt_padded,
    output logic [31:0] cnt_short,
    output logic [31:0] cnt_len_err,
`endif
    output logic [18:0] stat_tdata
);
    state_t      state;
    logic [15:0] cnt, len, cur_len;
    logic        len_err, cur_err, lsb, len_hit, pass_st, out_ready, fwd, drop_acc, stat_done;
    stat_word_t  stat_r, fin;
    always_comb begin
        pass_st   = state == HDR || state == PASS;
        lsb       = state == HDR && cnt == 16'(LEN_OFFSET + 1);
        cur_len   = lsb ? {len[15:8], s_tdata} : len;
        cur_err   = lsb ? (cur_len < 16'(MIN_LEN) || cur_len > 16'(MAX_LEN)) : len_err;
        len_hit   = (state == PASS || lsb) && !cur_err && cnt == cur_len - 16'd1;
        // A frame ending before the LSB arrives never captured a length
        fin       = {cur_err, !len_hit && !cur_err, 1'b0, (lsb || state != HDR) ? cur_len : 16'd0};
        s_tready  = state == DROP || (pass_st && out_ready);
        fwd       = s_tvalid && pass_st && out_ready;
        drop_acc  = s_tvalid && state == DROP;
        stat_done = stat_tvalid && stat_tready;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HDR;
            cnt         <= 16'd0;
            len         <= 16'd0;
            len_err     <= 1'b0;
            stat_tvalid <= 1'b0;
            stat_r      <= '0;
        end else begin
            if (fwd || drop_acc) cnt <= cnt + {15'd0, cnt != 16'hFFFF};
            if (fwd && state == HDR && cnt == 16'(LEN_OFFSET)) len[15:8] <= s_tdata;
            if (fwd && lsb) begin
                len[7:0] <= s_tdata;
                len_err  <= cur_err;
                state    <= PASS;
            end
            if (fwd && (s_tlast || len_hit)) begin
                if (len_hit && !s_tlast) state <= DROP;
                else begin
                    state       <= STAT;
                    stat_tvalid <= 1'b1;
                    stat_r      <= fin;
                end
            end
            if (drop_acc && s_tlast) begin
                state       <= STAT;
                stat_tvalid <= 1'b1;
                stat_r      <= {3'b001, len};
            end
            if (stat_done) begin
                state       <= HDR;
                stat_tvalid <= 1'b0;
                cnt         <= 16'd0;
                len         <= 16'd0;
                len_err     <= 1'b0;
            end
        end
    end
    assign stat_tdata = stat_r;
    iplen_out_reg u_out (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (s_tvalid && pass_st),
        .in_ready (out_ready),
        .in_data  (s_tdata),
        .in_last  (s_tlast || len_hit),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .m_tlast  (m_tlast)
    );
`ifdef IPLEN_TRIM_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
    endfunction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_frames  <= 32'd0;
            cnt_padded  <= 32'd0;
            cnt_short   <= 32'd0;
            cnt_len_err <= 32'd0;
        end else if (stat_done) begin
            cnt_frames  <= sat_inc(cnt_frames, 1'b1);
            cnt_padded  <= sat_inc(cnt_padded, stat_tdata[STAT_PADDED_BIT]);
            cnt_short   <= sat_inc(cnt_short, stat_tdata[STAT_SHORT_BIT]);
            cnt_len_err <= sat_inc(cnt_len_err, stat_tdata[STAT_LEN_ERR_BIT]);
        end
    end
`endif
endmodule

// File: tb/tb_iplen_trim.sv
// tb_iplen_trim: directed frames and backpressured back-to-back traffic checked against a frame-level trim model.
`timescale 1ns/1ps
module tb_iplen_trim;
    logic        clk = 0, rst_n = 0, s_tvalid = 0, s_tlast = 0, m_tready = 1, stat_tready = 1;
    logic [7:0]  s_tdata = 0;
    logic        s_tready, m_tvalid, m_tlast, stat_tvalid;
    logic [7:0]  m_tdata;
    logic [18:0] stat_tdata;
    int          errors = 0, checks = 0, out_cnt = 0, stat_cnt = 0;
    logic [8:0]  exp_q[$];
    logic [18:0] exp_st[$];
    logic [7:0]  frm[$];
    logic [18:0] last_stat = 0;
    logic [8:0]  hold_v = 0;
    bit          chk_en = 0, bp = 0, gaps = 0, stall = 0;

    always #5 clk = ~clk;

    iplen_trim dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_tvalid    (s_tvalid),
        .s_tready    (s_tready),
        .s_tdata     (s_tdata),
        .s_tlast     (s_tlast),
        .m_tvalid    (m_tvalid),
        .m_tready    (m_tready),
        .m_tdata     (m_tdata),
        .m_tlast     (m_tlast),
        .stat_tvalid (stat_tvalid),
        .stat_tready (stat_tready),
        .stat_tdata  (stat_tdata)
    );

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Expected output bytes and status straight from the frame-length rules
    task automatic model();
        int n = frm.size();
        int l, nout;
        logic [2:0] fl;
        logic [15:0] lr;
        if (n < 4) begin
            nout = n; fl = 3'b010; lr = 16'd0;
        end else begin
            l = {16'd0, frm[2], frm[3]};
            lr = 16'(l);
            if (l < 20 || l > 1500) begin nout = n; fl = 3'b100; end
            else if (n == l) begin nout = n; fl = 3'b000; end
            else if (n > l) begin nout = l; fl = 3'b001; end
            else begin nout = n; fl = 3'b010; end
        end
        for (int i = 0; i < nout; i++) exp_q.push_back({i == nout - 1, frm[i]});
        exp_st.push_back({fl, lr});
    endtask

    always begin
        @(posedge clk); #1;
        m_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        stat_tready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    always @(negedge clk) begin
        if (!rst_n) stall = 0;
        else begin
            if (stall) check("m_hold", {23'd0, m_tvalid, m_tlast, m_tdata}, {23'd0, 1'b1, hold_v});
            stall = m_tvalid && !m_tready;
            hold_v = {m_tlast, m_tdata};
            if (chk_en && m_tvalid && m_tready) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL m_extra got=%0h exp=none", {m_tlast, m_tdata});
                end else check("m_byte", {23'd0, m_tlast, m_tdata}, {23'd0, exp_q.pop_front()});
            end
            if (chk_en && stat_tvalid && stat_tready) begin
                stat_cnt++;
                last_stat = stat_tdata;
                if (exp_st.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL stat_extra got=%0h exp=none", stat_tdata);
                end else check("stat", {13'd0, stat_tdata}, {13'd0, exp_st.pop_front()});
            end
        end
    end

    task automatic send_frame(input int n, input logic [15:0] lf, input int seed, input int stop);
        int t;
        frm.delete();
        for (int i = 0; i < n; i++) frm.push_back(i == 2 ? lf[15:8] : i == 3 ? lf[7:0] : 8'(i * 7 + seed));
        if (chk_en) model();
        for (int i = 0; i < stop; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_tvalid = 0; @(posedge clk); #1;
            end
            s_tvalid = 1; s_tdata = frm[i]; s_tlast = i == n - 1;
            t = 0;
            do begin @(negedge clk); t++; end while (!s_tready && t < 4000);
            if (t >= 4000) check("s_tready_timeout", {31'd0, s_tready}, 1);
            @(posedge clk); #1;
        end
        s_tvalid = 0; s_tlast = 0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || exp_st.size() != 0) && t < 4000) begin
            @(negedge clk); t++;
        end
        check("drain", 32'(exp_q.size() + exp_st.size()), 0);
        @(posedge clk); #1;
    endtask

    task automatic run(input string nm, input int n, input logic [15:0] lf, input logic [18:0] es, input int eo);
        out_cnt = 0;
        send_frame(n, lf, n, n);
        drain();
        check({nm, "_stat"}, {13'd0, last_stat}, {13'd0, es});
        check({nm, "_nout"}, 32'(out_cnt), 32'(eo));
    endtask

    initial begin
        int sc0;
        #12;
        check("rst_m_tvalid", {31'd0, m_tvalid}, 0);
        check("rst_m_tdata", {24'd0, m_tdata}, 0);
        check("rst_m_tlast", {31'd0, m_tlast}, 0);
        check("rst_stat_tvalid", {31'd0, stat_tvalid}, 0);
        check("rst_stat_tdata", {13'd0, stat_tdata}, 0);
        check("rst_s_tready", {31'd0, s_tready}, 1);
        @(posedge clk); #1 rst_n = 1;
        chk_en = 1;
        run("pad20", 46, 16'h0014, 19'h10014, 20);
        run("exact60", 60, 16'h003C, 19'h0003C, 60);
        run("short30", 30, 16'h0040, 19'h20040, 30);
        run("tiny3", 3, 16'h0000, 19'h20000, 3);
        run("lenlo", 40, 16'h0005, 19'h40005, 40);
        run("lenhi", 40, 16'h0600, 19'h40600, 40);
        run("min4", 4, 16'h0014, 19'h20014, 4);
        run("len19", 25, 16'h0013, 19'h40013, 25);
        run("len1501", 30, 16'd1501, 19'h405DD, 30);
        run("max1500", 1500, 16'd1500, 19'h005DC, 1500);
        run("pad1500", 1510, 16'd1500, 19'h105DC, 1500);
        bp = 1; gaps = 1;
        sc0 = stat_cnt;
        for (int k = 0; k < 12; k++) begin
            int n = $urandom_range(3, 80);
            send_frame(n, 16'($urandom_range(15, 90)), k * 13, n);
        end
        drain();
        check("b2b_stat_cnt", 32'(stat_cnt - sc0), 12);
        run("bp_pad", 46, 16'h0014, 19'h10014, 20);
        run("bp_short", 30, 16'h0040, 19'h20040, 30);
        bp = 0; gaps = 0;
        chk_en = 0;
        send_frame(60, 16'h003C, 5, 10);
        @(posedge clk); #3 rst_n = 0;
        #1;
        check("midrst_m_tvalid", {31'd0, m_tvalid}, 0);
        check("midrst_stat_tvalid", {31'd0, stat_tvalid}, 0);
        exp_q.delete(); exp_st.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        chk_en = 1;
        run("post_rst", 60, 16'h003C, 19'h0003C, 60);
        run("post_rst_pad", 46, 16'h0014, 19'h10014, 20);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
